uart_rx_cfg: RTL and testbench

Parametrised UART receiver, next generation of the demo UART RX. Generalises frame format (data width, parity mode, stop-bit count) and bit timing. Adds 3-sample majority voting, false-start rejection, parity/framing error flags, overrun and break detection. Sits between the board RX pin and a valid/ready consumer, such as the UART TX for loopback or a FIFO.

---
 rtl/uart_rx_cfg.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop sync, 3-sample majority vote, parity/framing/overrun/break.
// Word held on a valid/ready output; a word completing while the held word is unaccepted is dropped.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 voted_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_S2   = CW'(H + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rs, rs_prev;
  logic [CW-1:0]          cnt;
  logic                   s0, s1;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   ferr_acc;

  logic                   counting, vote_now, vote, bit_end;
  logic                   last_data, last_stop, break_cond;
  logic                   pxor, perr;
  logic                   done, brk_hit;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
      rs_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
      rs_prev <= rs;
    end
  end

  assign counting   = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign vote_now   = counting && (cnt == CNT_S2);
  assign bit_end    = (cnt == CNT_LAST);
  assign vote       = (s0 & s1) | (s0 & rs) | (s1 & rs);
  assign last_data  = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop  = (bit_idx == 4'(STOP_BITS - 1));
  // Break: an all-zero frame, judged at the first stop bit's vote.
  assign break_cond = (shreg == '0) && ((PARITY_MODE == 0) || !par_bit) && !vote && (bit_idx == 4'd0);
  assign pxor       = (^shreg) ^ par_bit;
  assign perr       = (PARITY_MODE == 1) ? pxor : (PARITY_MODE == 2) ? ~pxor : 1'b0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    brk_hit   = 1'b0;
    case (state)
      IDLE:   if (rs_prev && !rs) state_nxt = START;
      START: begin
        if (vote_now && vote) state_nxt = IDLE;
        else if (bit_end)     state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && last_data) state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP: begin
        if (vote_now && break_cond) begin
          brk_hit   = 1'b1;
          state_nxt = BREAK;
        end else if (vote_now && last_stop) begin
          // Return to IDLE mid-bit so a back-to-back start edge is not missed.
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      BREAK:  if (rs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt      <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      voted_o  <= 1'b1;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (!counting || bit_end) cnt <= '0;
      else                      cnt <= cnt + CW'(1);

      if (counting && cnt == CNT_S0) s0 <= rs;
      if (counting && cnt == CNT_S1) s1 <= rs;
      if (vote_now) voted_o <= vote;

      case (state)
        START: begin
          bit_idx  <= '0;
          ferr_acc <= 1'b0;
        end
        DATA: begin
          if (vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end)  bit_idx <= last_data ? 4'd0 : bit_idx + 4'd1;
        end
        PARITY: if (vote_now) par_bit <= vote;
        STOP: begin
          if (vote_now && !vote) ferr_acc <= 1'b1;
          if (bit_end)           bit_idx  <= bit_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= brk_hit;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr;
          frame_err  <= ferr_acc | ~vote;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances (8N1, 8E1, 8O1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       nreset;
  logic       rx    [4];
  logic       ready [4];
  logic [7:0] data  [4];
  logic       vld   [4];
  logic       pe    [4];
  logic       fe    [4];
  logic       ovr   [4];
  logic       brk   [4];
  logic       vot   [4];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .nreset(nreset), .rx(rx[0]), .rx_data(data[0]), .rx_valid(vld[0]),
    .rx_ready(ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
    .break_det(brk[0]), .voted_o(vot[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .nreset(nreset), .rx(rx[1]), .rx_data(data[1]), .rx_valid(vld[1]),
    .rx_ready(ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
    .break_det(brk[1]), .voted_o(vot[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .clk(clk), .nreset(nreset), .rx(rx[2]), .rx_data(data[2]), .rx_valid(vld[2]),
    .rx_ready(ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]),
    .break_det(brk[2]), .voted_o(vot[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .clk(clk), .nreset(nreset), .rx(rx[3]), .rx_data(data[3]), .rx_valid(vld[3]),
    .rx_ready(ready[3]), .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ovr[3]),
    .break_det(brk[3]), .voted_o(vot[3]));

  typedef struct packed {
    logic [1:0] dut;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  // Accepted words are logged by the monitor; the test reads them in order.
  word_t wbuf [256];
  int    wr_idx = 0;
  int    rd_idx = 0;
  int    ovr_cnt [4] = '{0, 0, 0, 0};
  int    brk_cnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && ready[i]) begin
        wbuf[wr_idx[7:0]] <= '{dut: 2'(i), d: data[i], pe: pe[i], fe: fe[i]};
        wr_idx <= wr_idx + 1;
      end
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int i, input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rx[i] = v;
    end
  endtask

  task automatic drive_bit(input int i, input logic v, input int spike);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      rx[i] = (c == spike) ? ~v : v;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic p, input logic [1:0] sv,
                      input int spike_bit);
    drive_bit(i, 1'b0, -1);
    for (int b = 0; b < 8; b++) drive_bit(i, d[b], (b == spike_bit) ? 9 : -1);
    if (i == 1 || i == 2) drive_bit(i, p, -1);
    drive_bit(i, sv[0], -1);
    if (i == 3) drive_bit(i, sv[1], -1);
  endtask

  task automatic expect_word(input string nm, input int i, input logic [7:0] d,
                             input logic p, input logic f);
    word_t w;
    if (rd_idx >= wr_idx) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no word received, want data 0x%0h", nm, d);
    end else begin
      w = wbuf[rd_idx[7:0]];
      rd_idx++;
      chk({nm, ".dut"},  32'(w.dut), 32'(i));
      chk({nm, ".data"}, 32'(w.d),   32'(d));
      chk({nm, ".perr"}, 32'(w.pe),  32'(p));
      chk({nm, ".ferr"}, 32'(w.fe),  32'(f));
    end
  endtask

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       par;
    logic [1:0] sv;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vt [10];
  int   o, b;

  initial begin
    vt[0] = '{0, 8'h43, 1'b0, 2'b11, 8'h43, 1'b0, 1'b0};
    vt[1] = '{0, 8'h81, 1'b0, 2'b10, 8'h81, 1'b0, 1'b1};
    vt[2] = '{1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
    vt[3] = '{1, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
    vt[4] = '{2, 8'h07, 1'b1, 2'b11, 8'h07, 1'b1, 1'b0};
    vt[5] = '{2, 8'h07, 1'b0, 2'b11, 8'h07, 1'b0, 1'b0};
    vt[6] = '{3, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1};
    vt[7] = '{3, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vt[8] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    vt[9] = '{1, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};

    nreset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx[i]    = 1'b1;
      ready[i] = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk("rst.valid", 32'(vld[0]), 32'd0);
    chk("rst.data",  32'(data[0]), 32'd0);
    chk("rst.voted", 32'(vot[0]), 32'd1);
    chk("rst.flags", {28'd0, pe[0], fe[0], ovr[0], brk[0]}, 32'd0);
    @(posedge clk); #1;
    nreset = 1'b1;
    hold(0, 1'b1, 10);

    for (int k = 0; k < 10; k++) begin
      send(vt[k].dut, vt[k].d, vt[k].par, vt[k].sv, -1);
      hold(vt[k].dut, 1'b1, 24);
      expect_word($sformatf("vec%0d", k), vt[k].dut, vt[k].ed, vt[k].ep, vt[k].ef);
    end

    // Back-to-back frames with the consumer always ready.
    o = ovr_cnt[0];
    send(0, 8'h43, 1'b0, 2'b11, -1);
    send(0, 8'h44, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 24);
    expect_word("b2b.first", 0, 8'h43, 1'b0, 1'b0);
    expect_word("b2b.second", 0, 8'h44, 1'b0, 1'b0);
    chk("b2b.overrun", 32'(ovr_cnt[0] - o), 32'd0);

    // Consumer stalled: second word is dropped with one overrun pulse.
    @(posedge clk); #1;
    ready[0] = 1'b0;
    o = ovr_cnt[0];
    send(0, 8'h55, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 8);
    send(0, 8'hAA, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 24);
    @(negedge clk);
    chk("ovr.valid_held", 32'(vld[0]), 32'd1);
    chk("ovr.data_held", 32'(data[0]), 32'h55);
    chk("ovr.pulses", 32'(ovr_cnt[0] - o), 32'd1);
    @(posedge clk); #1;
    ready[0] = 1'b1;
    hold(0, 1'b1, 6);
    @(negedge clk);
    chk("ovr.valid_drop", 32'(vld[0]), 32'd0);
    expect_word("ovr.accepted", 0, 8'h55, 1'b0, 1'b0);
    chk("ovr.no_extra", 32'(wr_idx - rd_idx), 32'd0);

    // False start, then a glitched data bit that the vote must reject.
    hold(0, 1'b0, 3);
    hold(0, 1'b1, 48);
    chk("fstart.no_word", 32'(wr_idx - rd_idx), 32'd0);
    send(0, 8'h5A, 1'b0, 2'b11, 1);
    hold(0, 1'b1, 24);
    expect_word("spike", 0, 8'h5A, 1'b0, 1'b0);

    // Break: line low for 12 bit times.
    o = ovr_cnt[0];
    b = brk_cnt[0];
    hold(0, 1'b0, 192);
    hold(0, 1'b1, 32);
    chk("brk.pulses", 32'(brk_cnt[0] - b), 32'd1);
    chk("brk.no_word", 32'(wr_idx - rd_idx), 32'd0);
    chk("brk.overrun", 32'(ovr_cnt[0] - o), 32'd0);
    send(0, 8'h5A, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 24);
    expect_word("brk.after", 0, 8'h5A, 1'b0, 1'b0);

    // Reset mid-frame while a word is held.
    @(posedge clk); #1;
    ready[0] = 1'b0;
    send(0, 8'h11, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 24);
    @(negedge clk);
    chk("mrst.pre_valid", 32'(vld[0]), 32'd1);
    drive_bit(0, 1'b0, -1);
    drive_bit(0, 1'b0, -1);
    drive_bit(0, 1'b0, -1);
    @(posedge clk); #1;
    nreset = 1'b0;
    rx[0]  = 1'b1;
    @(negedge clk);
    chk("mrst.valid", 32'(vld[0]), 32'd0);
    chk("mrst.data",  32'(data[0]), 32'd0);
    chk("mrst.voted", 32'(vot[0]), 32'd1);
    chk("mrst.flags", {28'd0, pe[0], fe[0], ovr[0], brk[0]}, 32'd0);
    hold(0, 1'b1, 3);
    nreset   = 1'b1;
    ready[0] = 1'b1;
    hold(0, 1'b1, 20);
    send(0, 8'h3C, 1'b0, 2'b11, -1);
    hold(0, 1'b1, 24);
    expect_word("mrst.after", 0, 8'h3C, 1'b0, 1'b0);
    chk("end.no_extra", 32'(wr_idx - rd_idx), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
